// File: rtl/tick_monitor_pkg.sv
// +----------------------------------------------------------------------------+
// | tick_monitor_pkg : shared state type and default constants for tick_monitor |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package tick_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    FAULT   = 2'd2
  } tick_state_e;

  localparam int PERIOD_DEF = 20001;
  localparam int CBITS_DEF  = 15;
  localparam int SEQ_W_DEF  = 8;

endpackage

`default_nettype wire

// File: rtl/tick_evt_slot.sv
// +----------------------------------------------------------------------------+
// | tick_evt_slot : single-entry tick event register with overrun detection     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tick_evt_slot
  import tick_monitor_pkg::*;
#(
  parameter int SEQ_W = SEQ_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             ready,
  output logic             valid,
  output logic [SEQ_W-1:0] seq,
  output logic             overrun
);

  logic [SEQ_W-1:0] r_next_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_seq <= '0;
      valid      <= 1'b0;
      seq        <= '0;
      overrun    <= 1'b0;
    end else begin
      // A newer event replacing one the consumer has not taken is an overrun.
      overrun <= load & valid & ~ready;
      if (load) begin
        seq        <= r_next_seq;
        r_next_seq <= r_next_seq + SEQ_W'(1);
        valid      <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tick_monitor.sv
// +----------------------------------------------------------------------------+
// | tick_monitor : checks tick spacing against PERIOD and queues tick events.   |
// | Option TICK_MONITOR_STICKY_EN: fault is terminal and error flags latch.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tick_monitor
  import tick_monitor_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF,
  parameter int CBITS  = CBITS_DEF,
  parameter int SEQ_W  = SEQ_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [SEQ_W-1:0] evt_seq,
  output logic             locked,
  output logic             err_early,
  output logic             err_late,
  output logic             overrun
);

  localparam logic [CBITS-1:0] C_PERIOD_M1 = CBITS'(PERIOD - 1);

  tick_state_e      r_state;
  tick_state_e      w_state_nxt;
  logic [CBITS-1:0] r_icnt;
  logic             w_locked_nxt;
  logic             w_early_nxt;
  logic             w_late_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_icnt    <= '0;
      locked    <= 1'b0;
      err_early <= 1'b0;
      err_late  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      locked    <= w_locked_nxt;
      err_early <= w_early_nxt;
      err_late  <= w_late_nxt;
      if (tick) begin
        r_icnt <= '0;
      end else if (r_icnt != '1) begin
        r_icnt <= r_icnt + CBITS'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_locked_nxt = locked;
`ifdef TICK_MONITOR_STICKY_EN
    w_early_nxt  = err_early;
    w_late_nxt   = err_late;
`else
    w_early_nxt  = 1'b0;
    w_late_nxt   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (tick) begin
          w_state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        // A tick with icnt past PERIOD-1 (after a late fault) simply restarts the interval.
        if (tick) begin
          if (r_icnt == C_PERIOD_M1) begin
            w_locked_nxt = 1'b1;
          end else if (r_icnt < C_PERIOD_M1) begin
            w_early_nxt  = 1'b1;
            w_locked_nxt = 1'b0;
            w_state_nxt  = FAULT;
          end
        end else if (r_icnt == C_PERIOD_M1) begin
          w_late_nxt   = 1'b1;
          w_locked_nxt = 1'b0;
          w_state_nxt  = FAULT;
        end
      end
      FAULT: begin
`ifdef TICK_MONITOR_STICKY_EN
        w_state_nxt = FAULT;
`else
        w_state_nxt = MEASURE;
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  tick_evt_slot #(
    .SEQ_W(SEQ_W)
  ) u_evt_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tick),
    .ready  (evt_ready),
    .valid  (evt_valid),
    .seq    (evt_seq),
    .overrun(overrun)
  );

endmodule

`default_nettype wire
